paddle_position: RTL

Converts the two 16-bit rotary-encoder running counts into per-player paddle X coordinates, one update per video frame. It sits directly downstream of the encoder counters and upstream of the renderer and catch-collision logic. Each frame it:
- snapshots both counts,
- computes the wrap-safe signed movement since the last frame,
- scales the movement and rate-limits it,
- applies it to each paddle position, saturating at the screen edges.

---
 rtl/paddle_position.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/paddle_position.sv
// paddle_position
//   Converts two free-running 16-bit rotary-encoder counts into per-player
//   paddle X coordinates, updating once per video frame. A single shared
//   delta/clamp datapath serves the left player first, then the right.
//
//   Optional build macro: PADDLE_SPEED_LIMIT_EN
//     defined   -> per-frame movement is saturated to +/-MAX_SPEED pixels
//     undefined -> the scaled encoder delta is applied unlimited
//                  (MAX_SPEED is then unused)
//
//   Ports:
//     clk          system clock, rising edge
//     reset        synchronous, active-low reset
//     frame_tick   one-cycle pulse at start of vertical blank
//     count_l/r    left/right encoder running counts (wrap freely)
//     pos_l/r      paddle left-edge X, 0..SCREEN_W-PADDLE_W
//     busy         high while an update is in progress
//     update_done  one-cycle pulse when both positions are final
//     overrun      sticky: a frame_tick arrived while busy
module paddle_position #(
    parameter int SCREEN_W   = 640,
    parameter int PADDLE_W   = 64,
    parameter int STEP_SHIFT = 1,
    parameter int MAX_SPEED  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [15:0] count_l,
    input  logic [15:0] count_r,
    output logic [9:0]  pos_l,
    output logic [9:0]  pos_r,
    output logic        busy,
    output logic        update_done,
    output logic        overrun
);

    localparam int POS_MAX   = SCREEN_W - PADDLE_W;
    localparam int POS_RESET = POS_MAX / 2;

    typedef enum logic [2:0] {
        IDLE,
        CALC_L,
        APPLY_L,
        CALC_R,
        APPLY_R
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        snap_l_q, snap_l_d;
    logic [15:0]        snap_r_q, snap_r_d;
    logic [15:0]        prev_l_q, prev_l_d;
    logic [15:0]        prev_r_q, prev_r_d;
    logic               primed_q, primed_d;
    logic signed [19:0] delta_q, delta_d;
    logic [9:0]         pos_l_q, pos_l_d;
    logic [9:0]         pos_r_q, pos_r_d;
    logic               update_done_q, update_done_d;
    logic               overrun_q, overrun_d;

    // Shared datapath signals
    logic [15:0]        cur_snap;
    logic [15:0]        cur_prev;
    logic [9:0]         cur_pos;
    logic [15:0]        raw_diff;
    logic signed [19:0] scaled;
    logic signed [19:0] limited;
    logic signed [20:0] sum;
    logic [9:0]         clamped;

    always_comb begin
        cur_snap = (state_q == CALC_L) ? snap_l_q : snap_r_q;
        cur_prev = (state_q == CALC_L) ? prev_l_q : prev_r_q;
        cur_pos  = (state_q == APPLY_L) ? pos_l_q : pos_r_q;

        // Modulo-2^16 subtraction reinterpreted as signed gives the
        // shortest movement across a counter wrap.
        raw_diff = cur_snap - cur_prev;
        scaled   = $signed({{4{raw_diff[15]}}, raw_diff}) <<< STEP_SHIFT;

`ifdef PADDLE_SPEED_LIMIT_EN
        if (scaled > 20'(MAX_SPEED)) begin
            limited = 20'(MAX_SPEED);
        end else if (scaled < -20'(MAX_SPEED)) begin
            limited = -20'(MAX_SPEED);
        end else begin
            limited = scaled;
        end
`else
        limited = scaled;
`endif

        // Sum kept wide enough that an unlimited delta cannot wrap before
        // the edge clamp sees it.
        sum = $signed({11'b0, cur_pos}) + $signed({delta_q[19], delta_q});
        if (sum < 0) begin
            clamped = '0;
        end else if (sum > 21'(POS_MAX)) begin
            clamped = 10'(POS_MAX);
        end else begin
            clamped = sum[9:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        snap_l_d      = snap_l_q;
        snap_r_d      = snap_r_q;
        prev_l_d      = prev_l_q;
        prev_r_d      = prev_r_q;
        primed_d      = primed_q;
        delta_d       = delta_q;
        pos_l_d       = pos_l_q;
        pos_r_d       = pos_r_q;
        update_done_d = 1'b0;
        overrun_d     = overrun_q | (frame_tick && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    snap_l_d = count_l;
                    snap_r_d = count_r;
                    state_d  = CALC_L;
                end
            end
            CALC_L: begin
                // First frame after reset only establishes the baseline.
                delta_d  = primed_q ? limited : '0;
                prev_l_d = snap_l_q;
                state_d  = APPLY_L;
            end
            APPLY_L: begin
                pos_l_d = clamped;
                state_d = CALC_R;
            end
            CALC_R: begin
                delta_d  = primed_q ? limited : '0;
                prev_r_d = snap_r_q;
                state_d  = APPLY_R;
            end
            APPLY_R: begin
                pos_r_d       = clamped;
                update_done_d = 1'b1;
                primed_d      = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            snap_l_q      <= '0;
            snap_r_q      <= '0;
            prev_l_q      <= '0;
            prev_r_q      <= '0;
            primed_q      <= 1'b0;
            delta_q       <= '0;
            pos_l_q       <= 10'(POS_RESET);
            pos_r_q       <= 10'(POS_RESET);
            update_done_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_l_q      <= snap_l_d;
            snap_r_q      <= snap_r_d;
            prev_l_q      <= prev_l_d;
            prev_r_q      <= prev_r_d;
            primed_q      <= primed_d;
            delta_q       <= delta_d;
            pos_l_q       <= pos_l_d;
            pos_r_q       <= pos_r_d;
            update_done_q <= update_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign pos_l       = pos_l_q;
    assign pos_r       = pos_r_q;
    assign busy        = (state_q != IDLE);
    assign update_done = update_done_q;
    assign overrun     = overrun_q;

endmodule
